// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit_if
// Brief    : CPU-side request/response and memory-beat bundle of the LSU.
// Revision : 1.0 - initial release
// ============================================================================
interface load_store_unit_if #(
    parameter int WIDTH = 32
) ();
    logic             req_valid;
    logic             req_ready;
    logic             req_we;
    logic [2:0]       req_mode;
    logic [WIDTH-1:0] req_addr;
    logic [WIDTH-1:0] req_wdata;

    logic             rsp_valid;
    logic [WIDTH-1:0] rsp_rdata;
    logic             rsp_err;

    logic             mem_req;
    logic             mem_we;
    logic [WIDTH-1:0] mem_addr;
    logic [3:0]       mem_be;
    logic [WIDTH-1:0] mem_wdata;
    logic             mem_ack;
    logic [WIDTH-1:0] mem_rdata;

    // master: the load/store unit itself
    modport master (
        input  req_valid, req_we, req_mode, req_addr, req_wdata,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ack, mem_rdata
    );

    // slave: the CPU execute stage and the data memory seen together
    modport slave (
        output req_valid, req_we, req_mode, req_addr, req_wdata,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Brief    : Big-endian load/store initiator; splits misaligned accesses into
//            two word beats, merges and extends load data.
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter int WIDTH = 32
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    load_store_unit_if.master  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BEAT0 = 2'd1,
        S_BEAT1 = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic             r_we;
    logic [2:0]       r_mode;
    logic [WIDTH-1:0] r_addr;
    logic [WIDTH-1:0] r_wdata;
    logic [WIDTH-1:0] r_rd0;
    logic [WIDTH-1:0] r_rsp_rdata;
    logic             r_rsp_err;

    logic             w_req_legal;
    logic             w_accept;
    logic [3:0]       w_size_mask;
    logic [4:0]       w_rjsh;
    logic             w_signed;
    logic [1:0]       w_off;
    logic [7:0]       w_lanes;
    logic             w_split;
    logic [WIDTH-1:0] w_base;
    logic [WIDTH-1:0] w_wjust;
    logic [2*WIDTH-1:0] w_wstream;
    logic [55:0]      w_rstream;
    logic [WIDTH-1:0] w_rtop;
    logic [WIDTH-1:0] w_rjust;
    logic [WIDTH-1:0] w_load;
    logic             w_final_ack;
    logic             w_in_beat;

    assign w_req_legal = (bus.req_mode != 3'd0) && (bus.req_mode <= 3'd5);
    assign w_accept    = (r_state == S_IDLE) && bus.req_valid;

    // Size mask is left-justified (offset 0 = bit 3); w_rjsh right-justifies data
    always_comb begin
        w_size_mask = 4'b0000;
        w_rjsh      = 5'd0;
        w_signed    = 1'b0;
        case (r_mode)
            3'b001: begin w_size_mask = 4'b1111; w_rjsh = 5'd0;  w_signed = 1'b0; end
            3'b010: begin w_size_mask = 4'b1100; w_rjsh = 5'd16; w_signed = 1'b1; end
            3'b011: begin w_size_mask = 4'b1000; w_rjsh = 5'd24; w_signed = 1'b1; end
            3'b100: begin w_size_mask = 4'b1100; w_rjsh = 5'd16; w_signed = 1'b0; end
            3'b101: begin w_size_mask = 4'b1000; w_rjsh = 5'd24; w_signed = 1'b0; end
            default: begin w_size_mask = 4'b0000; w_rjsh = 5'd0; w_signed = 1'b0; end
        endcase
    end

    assign w_off   = r_addr[1:0];
    assign w_base  = {r_addr[WIDTH-1:2], 2'b00};
    // Upper nibble: beat0 enables, lower nibble: beat1 enables
    assign w_lanes = {w_size_mask, 4'b0000} >> w_off;
    assign w_split = |w_lanes[3:0];

    assign w_wjust   = r_wdata << w_rjsh;
    assign w_wstream = {w_wjust, {WIDTH{1'b0}}} >> {w_off, 3'b000};

    // Byte stream in address order: beat0 word then the first three bytes of beat1
    assign w_rstream = (r_state == S_BEAT1) ? {r_rd0, bus.mem_rdata[31:8]}
                                            : {bus.mem_rdata, 24'h000000};

    always_comb begin
        w_rtop = w_rstream[55:24];
        case (w_off)
            2'd0:    w_rtop = w_rstream[55:24];
            2'd1:    w_rtop = w_rstream[47:16];
            2'd2:    w_rtop = w_rstream[39:8];
            default: w_rtop = w_rstream[31:0];
        endcase
    end

    assign w_rjust = w_rtop >> w_rjsh;
    assign w_load  = (w_signed && w_rtop[WIDTH-1]) ? (w_rjust | ~({WIDTH{1'b1}} >> w_rjsh))
                                                   : w_rjust;

    assign w_in_beat   = (r_state == S_BEAT0) || (r_state == S_BEAT1);
    assign w_final_ack = bus.mem_ack &&
                         (((r_state == S_BEAT0) && !w_split) || (r_state == S_BEAT1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    w_next = w_req_legal ? S_BEAT0 : S_RESP;
                end
            end
            S_BEAT0: begin
                if (bus.mem_ack) begin
                    w_next = w_split ? S_BEAT1 : S_RESP;
                end
            end
            S_BEAT1: begin
                if (bus.mem_ack) begin
                    w_next = S_RESP;
                end
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_we        <= 1'b0;
            r_mode      <= 3'b000;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rd0       <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_we    <= bus.req_we;
                r_mode  <= bus.req_mode;
                r_addr  <= bus.req_addr;
                r_wdata <= bus.req_wdata;
                if (!w_req_legal) begin
                    r_rsp_err   <= 1'b1;
                    r_rsp_rdata <= '0;
                end
            end
            if ((r_state == S_BEAT0) && bus.mem_ack) begin
                r_rd0 <= bus.mem_rdata;
            end
            if (w_final_ack) begin
                r_rsp_err   <= 1'b0;
                r_rsp_rdata <= r_we ? '0 : w_load;
            end
        end
    end

    assign bus.req_ready = (r_state == S_IDLE);
    assign bus.rsp_valid = (r_state == S_RESP);
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;

    assign bus.mem_req   = w_in_beat;
    assign bus.mem_we    = w_in_beat && r_we;
    assign bus.mem_addr  = (r_state == S_BEAT0) ? w_base :
                           (r_state == S_BEAT1) ? (w_base + WIDTH'(4)) : '0;
    assign bus.mem_be    = (r_state == S_BEAT0) ? w_lanes[7:4] :
                           (r_state == S_BEAT1) ? w_lanes[3:0] : 4'b0000;
    assign bus.mem_wdata = (r_we && (r_state == S_BEAT0)) ? w_wstream[2*WIDTH-1:WIDTH] :
                           (r_we && (r_state == S_BEAT1)) ? w_wstream[WIDTH-1:0] : '0;

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the CPU data-memory interface for the multi-cycle/pipelined core.
- Accepts one load/store request at a time from the execute stage.
- Converts each request into word-aligned, byte-enabled memory beats, big-endian: byte offset 0 occupies bits 31:24.
- Splits misaligned accesses into two beats, merges and sign/zero-extends load data, and returns one response per request.

Parameters:
WIDTH, 32, data and address width.

Ports:
- clk  in  1  system clock, all state updates on posedge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  1  CPU request present.
- req_ready  out  1  unit idle and able to accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_mode  in  3  size/sign: 001 word, 010 half, 011 byte, 100 half unsigned, 101 byte unsigned.
- req_addr  in  WIDTH  byte address.
- req_wdata  in  WIDTH  store data, right-justified.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  WIDTH  extended load data; 0 for stores.
- rsp_err  out  1  illegal req_mode.
- mem_req  out  1  memory beat request.
- mem_we  out  1  beat is a write.
- mem_addr  out  WIDTH  word address, bits 1:0 always 00.
- mem_be  out  4  byte enables; be[3] is offset 0 (bits 31:24).
- mem_wdata  out  WIDTH  lane-aligned write data.
- mem_ack  in  1  beat complete; mem_rdata valid in the same cycle.
- mem_rdata  in  WIDTH  read word.

Behaviour:
- Reset (rst_n low at posedge):
  - State goes to IDLE.
  - rsp_valid, rsp_err, rsp_rdata, mem_req, mem_we, mem_addr, mem_be and mem_wdata all go to 0.
  - req_ready = 1 whenever state is IDLE.
  - Reset mid-operation abandons the access: mem_req is 0 from the next cycle and no response is issued.
- FSM states: IDLE, BEAT0, BEAT1, RESP.
  - IDLE: on req_valid && req_ready, capture the request.
    - Illegal mode goes to RESP with rsp_err = 1 and no memory beat.
    - Otherwise go to BEAT0.
  - BEAT0: mem_req = 1, with mem_we/mem_addr/mem_be/mem_wdata held stable until mem_ack.
    - On mem_ack, go to BEAT1 if the access is split, else RESP.
  - BEAT1: second beat at mem_addr + 4 (wraps modulo 2^32). On mem_ack, go to RESP.
  - RESP: rsp_valid = 1 for exactly one cycle, then IDLE. There is no response backpressure.
- Latency: accept at cycle T → mem_req at T+1.
  - Aligned access with immediate ack: rsp_valid at T+2.
  - Split access with immediate acks: rsp_valid at T+3.
  - mem_ack outside BEAT0/BEAT1 is ignored.
- Offset and enables: off = addr[1:0].
  - Byte: be = 1000 >> off.
  - Half: off 0..2 gives be = 1100 >> off. off 3 is split: beat0 be 0001, beat1 be 1000.
  - Word: off 0 gives be 1111. Otherwise split: beat0 be = 1111 >> off, beat1 be = ~(1111 >> off) & 1111.
- Store data:
  - The data bytes are placed in the enabled lanes, most-significant data byte at the lowest address.
  - Disabled lanes are driven 0.
- Load data:
  - Bytes are collected from the enabled lanes of beat0, then beat1, in address order.
  - Result is right-justified.
  - Modes 010/011 sign-extend from the top collected bit; modes 100/101 zero-extend.
- rsp_rdata and rsp_err hold their values until the next response. rsp_err is 0 for legal modes.
- req_ready is 0 in BEAT0, BEAT1 and RESP; a req_valid held high during those states is not accepted until IDLE.

Test Plan:
- Aligned SW 0xDEADBEEF @0x10, ack at T+1:
  - mem_addr 0x10, be 1111, wdata 0xDEADBEEF.
  - rsp_valid at T+2, rsp_rdata 0.
- SB 0xA5 @0x13 → be 0001, wdata 0x000000A5.
- SH 0x1234 @0x11 → be 0110, wdata 0x00123400.
- Split SW 0x11223344 @0x0E:
  - Beat0: addr 0x0C, be 0011, wdata 0x00001122.
  - Beat1: addr 0x10, be 1100, wdata 0x33440000.
  - rsp_valid at T+3.
- Loads with word 0x10 = 0x000000F0:
  - LB @0x13 → 0xFFFFFFF0.
  - LBU @0x13 → 0x000000F0.
  - LH @0x12 → 0x000000F0.
- Split LW @0x0E with word 0x0C = 0xAAAABBBB and word 0x10 = 0xCCCCDDDD → 0xBBBBCCCC.
- Illegal mode 110 → no mem_req, rsp_valid at T+1 with rsp_err 1.
- Reset mid-operation: rst_n low during BEAT0 with ack withheld 3 cycles → mem_req 0 next cycle, no rsp_valid, req_ready 1 after reset.
